// File: rtl/hwpe_multistream_fsm_if.sv
// Control bundle between the multistream FSM and the streamers, engine and ucode unit.
// The master side is the FSM; the slave side is the datapath it sequences.
interface hwpe_multistream_fsm_if #(
    parameter int unsigned N_SRC = 2,
    parameter int unsigned N_SNK = 1,
    parameter int unsigned CNT_W = 16
) ();
    // req_start launches a stream in the cycle it is high; the FSM raises it only when every
    // enabled stream shows ready_start in that same cycle. ucode_done is meaningful only with ucode_valid.
    logic [N_SRC-1:0] src_req_start;
    logic [N_SRC-1:0] src_ready_start;
    logic [N_SNK-1:0] snk_req_start;
    logic [N_SNK-1:0] snk_ready_start;
    logic             engine_start;
    logic             engine_clear;
    logic             engine_enable;
    logic             engine_ready;
    logic [CNT_W-1:0] engine_cnt;
    logic             ucode_enable;
    logic             ucode_clear;
    logic             ucode_valid;
    logic             ucode_done;

    modport master (
        output src_req_start, snk_req_start, engine_start, engine_clear, engine_enable,
        output ucode_enable, ucode_clear,
        input  src_ready_start, snk_ready_start, engine_ready, engine_cnt, ucode_valid, ucode_done
    );

    modport slave (
        input  src_req_start, snk_req_start, engine_start, engine_clear, engine_enable,
        input  ucode_enable, ucode_clear,
        output src_ready_start, snk_ready_start, engine_ready, engine_cnt, ucode_valid, ucode_done
    );
endinterface

// File: rtl/hwpe_multistream_fsm.sv
// Control FSM sequencing start, per-tile compute, index update and termination of a
// multi-stream HWPE job; per-stream masks select which streamers take part.
module hwpe_multistream_fsm #(
    parameter int unsigned N_SRC  = 2,
    parameter int unsigned N_SNK  = 1,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned TILE_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  start_i,
    input  logic [N_SRC-1:0]      src_mask_i,
    input  logic [N_SNK-1:0]      snk_mask_i,
    input  logic [CNT_W-1:0]      cnt_limit_i,
    hwpe_multistream_fsm_if.master ctrl,
    output logic                  done_o,
    output logic                  evt_o,
    output logic                  busy_o,
    output logic [TILE_W-1:0]     tile_cnt_o,
    output logic [2:0]            state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT      = 3'd2,
        COMPUTE   = 3'd3,
        UPDATEIDX = 3'd4,
        UPDWAIT   = 3'd5,
        TERMINATE = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [TILE_W-1:0]  tile_cnt_q, tile_cnt_d;
    logic [N_SRC-1:0]   src_mask_q, src_mask_d;
    logic [N_SNK-1:0]   snk_mask_q, snk_mask_d;

    logic               all_ready;
    logic               launch;
    logic [N_SRC-1:0]   src_req;
    logic [N_SNK-1:0]   snk_req;
    logic               eng_start, eng_clear, eng_enable;
    logic               uc_enable, uc_clear;
    logic               done, evt;

    // Disabled streams count as ready so a partial-stream kernel never stalls on them.
    assign all_ready = (&(ctrl.src_ready_start | ~src_mask_q)) &
                       (&(ctrl.snk_ready_start | ~snk_mask_q));

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q    <= IDLE;
            tile_cnt_q <= '0;
            src_mask_q <= '0;
            snk_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            tile_cnt_q <= tile_cnt_d;
            src_mask_q <= src_mask_d;
            snk_mask_q <= snk_mask_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tile_cnt_d = tile_cnt_q;
        src_mask_d = src_mask_q;
        snk_mask_d = snk_mask_q;
        launch     = 1'b0;
        src_req    = '0;
        snk_req    = '0;
        eng_start  = 1'b0;
        eng_clear  = 1'b1;
        eng_enable = 1'b1;
        uc_enable  = 1'b0;
        uc_clear   = 1'b0;
        done       = 1'b0;
        evt        = 1'b0;

        case (state_q)
            IDLE: begin
                uc_clear = 1'b1;
                if (start_i) begin
                    state_d    = START;
                    tile_cnt_d = '0;
                    src_mask_d = src_mask_i;
                    snk_mask_d = snk_mask_i;
                end
            end
            START: begin
                if (all_ready) begin
                    launch  = 1'b1;
                    state_d = COMPUTE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                eng_clear  = 1'b0;
                eng_enable = 1'b0;
                if (all_ready) begin
                    launch  = 1'b1;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                eng_clear = 1'b0;
                if (ctrl.engine_cnt == cnt_limit_i) begin
                    evt        = 1'b1;
                    tile_cnt_d = tile_cnt_q + TILE_W'(1);
                    state_d    = UPDATEIDX;
                end else if (ctrl.engine_ready) begin
                    eng_start = 1'b1;
                end
            end
            UPDATEIDX: begin
                eng_clear = 1'b0;
                uc_enable = 1'b1;
                state_d   = UPDWAIT;
            end
            UPDWAIT: begin
                eng_clear  = 1'b0;
                eng_enable = 1'b0;
                if (ctrl.ucode_valid) begin
                    if (ctrl.ucode_done) begin
                        state_d = TERMINATE;
                    end else if (all_ready) begin
                        launch  = 1'b1;
                        state_d = COMPUTE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            TERMINATE: begin
                eng_clear  = 1'b0;
                eng_enable = 1'b0;
                if (all_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A launch overrides the per-state engine controls in the cycle it happens.
        if (launch) begin
            src_req    = src_mask_q;
            snk_req    = snk_mask_q;
            eng_start  = 1'b1;
            eng_clear  = 1'b0;
            eng_enable = 1'b1;
        end
    end

    assign ctrl.src_req_start = src_req;
    assign ctrl.snk_req_start = snk_req;
    assign ctrl.engine_start  = eng_start;
    assign ctrl.engine_clear  = eng_clear;
    assign ctrl.engine_enable = eng_enable;
    assign ctrl.ucode_enable  = uc_enable;
    assign ctrl.ucode_clear   = uc_clear;

    assign done_o     = done;
    assign evt_o      = evt;
    assign busy_o     = (state_q != IDLE);
    assign tile_cnt_o = tile_cnt_q;
    assign state_o    = state_q;

endmodule
